// File: rtl/evm_pkg.sv
// Shared types and constants for the voting-machine ballot controller.
package evm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ARM,
        ARMED,
        QUALIFY,
        CAST,
        RELEASE
    } evm_ctrl_state_t;

    localparam int VOTE_W = 7;

    localparam logic [2:0] PARTY1 = 3'b001;
    localparam logic [2:0] PARTY2 = 3'b010;
    localparam logic [2:0] PARTY3 = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == PARTY1) || (v == PARTY2) || (v == PARTY3);
    endfunction

endpackage

// File: rtl/evm_switch_qualifier.sv
// Latches the voter switch pattern and counts how many consecutive edges it has held.
module evm_switch_qualifier
    import evm_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [2:0] switch_i,
    output logic       stable_o,
    output logic [2:0] pattern_o,
    output logic       onehot_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pattern_q, pattern_d;

    always_comb begin
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        if (!en_i || switch_i == 3'b000) begin
            cnt_d = '0;
        end else if (cnt_q == '0 || switch_i != pattern_q) begin
            // A new or different pattern restarts the stability run.
            pattern_d = switch_i;
            cnt_d     = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pattern_q <= pattern_d;
    end

    assign stable_o  = (cnt_q == CW'(STABLE_CYCLES));
    assign pattern_o = pattern_q;
    assign onehot_o  = is_onehot3(pattern_q);

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot session FSM: arms one ballot per officer press, qualifies the voter's
// choice, issues a single count enable and keeps the saturating vote tally.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MAX_VOTES      = 127
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              session_open_i,
    input  logic              ballot_arm_i,
    input  logic [2:0]        voter_switch_i,
    output logic              voting_en_o,
    output logic [2:0]        vote_sel_o,
    output logic              ballot_ready_o,
    output logic              invalid_o,
    output logic              timeout_o,
    output logic [VOTE_W-1:0] total_votes_o,
    output logic              session_full_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    evm_ctrl_state_t   state_q, state_d;
    logic              arm_prev_q;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              tmo_q, tmo_d;
    logic [VOTE_W-1:0] total_q, total_d;
    logic [2:0]        sel_q;

    logic              q_en, q_stable, q_onehot;
    logic [2:0]        q_pattern;
    logic              arm_edge, expired, sw_zero;

    assign q_en     = (state_q == ARMED) || (state_q == QUALIFY);
    assign arm_edge = ballot_arm_i && !arm_prev_q;
    assign expired  = q_en && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
    assign sw_zero  = (voter_switch_i == 3'b000);

    evm_switch_qualifier #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_qual (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (q_en),
        .switch_i (voter_switch_i),
        .stable_o (q_stable),
        .pattern_o(q_pattern),
        .onehot_o (q_onehot)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = 1'b0;
        total_d = total_q;
        case (state_q)
            IDLE:     if (session_open_i) state_d = WAIT_ARM;
            WAIT_ARM: if (arm_edge && !session_full_o && sw_zero) state_d = ARMED;
            ARMED: begin
                if (expired) begin
                    state_d = RELEASE;
                    tmo_d   = 1'b1;
                end else if (!sw_zero) begin
                    state_d = QUALIFY;
                end
            end
            QUALIFY: begin
                // A qualified cast wins over an expiry on the same edge.
                if (q_stable && q_onehot) begin
                    state_d = CAST;
                end else if (expired) begin
                    state_d = RELEASE;
                    tmo_d   = 1'b1;
                end else if (sw_zero) begin
                    state_d = ARMED;
                end
            end
            CAST: begin
                state_d = RELEASE;
                if (total_q != VOTE_W'(MAX_VOTES)) total_d = total_q + VOTE_W'(1);
            end
            RELEASE:  if (sw_zero) state_d = WAIT_ARM;
            default:  state_d = IDLE;
        endcase
        // Closing the session aborts any ballot; a cast already in flight still counts.
        if (!session_open_i) begin
            state_d = IDLE;
            tmo_d   = 1'b0;
        end
    end

    always_comb begin
        tmr_d = tmr_q;
        if (state_d == ARMED && state_q != ARMED) begin
            tmr_d = '0;
        end else if (q_en && !expired) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            arm_prev_q <= 1'b0;
            tmr_q      <= '0;
            tmo_q      <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            arm_prev_q <= ballot_arm_i;
            tmr_q      <= tmr_d;
            tmo_q      <= tmo_d;
            total_q    <= total_d;
        end
    end

    // The qualifier may relatch on the edge that enters CAST, so hold the selection here.
    always_ff @(posedge clk_i) begin
        if (state_d == CAST && state_q != CAST) sel_q <= q_pattern;
    end

    assign voting_en_o    = (state_q == CAST);
    assign vote_sel_o     = voting_en_o ? sel_q : 3'b000;
    assign ballot_ready_o = q_en;
    assign invalid_o      = (state_q == QUALIFY) && q_stable && !q_onehot;
    assign timeout_o      = tmo_q;
    assign total_votes_o  = total_q;
    assign session_full_o = (total_q == VOTE_W'(MAX_VOTES));

endmodule

// File: doc/evm_ballot_ctrl.md
# evm_ballot_ctrl

Session controller for the electronic voting machine. It sits between the presiding-officer controls and voter buttons on one side, and the per-party vote-counter datapath on the other. It arms exactly one ballot per officer request and qualifies the voter's switch pattern for stability and one-hot validity. It then issues a single-cycle count enable with a one-hot party select, and enforces timeout, release and vote-capacity rules.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive sampled edges a pattern must hold before it is acted on (>=1).
- TIMEOUT_CYCLES, 1023: cycles an armed ballot waits for a qualified pattern before being cancelled.
- MAX_VOTES, 127: session capacity; equals the counter datapath ceiling.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- session_open  in  1  level; election open while high.
- ballot_arm  in  1  officer button, synchronous to clk; rising edge arms one ballot.
- voter_switch  in  3  party buttons; bit0=party1, bit1=party2, bit2=party3; synchronous to clk.
- voting_en  out  1  one-cycle count enable to the counter datapath.
- vote_sel  out  3  one-hot party select; valid only while voting_en=1, else 000.
- ballot_ready  out  1  ballot armed; voter LED.
- invalid  out  1  qualified non-one-hot pattern present.
- timeout  out  1  one-cycle pulse when an armed ballot expires.
- total_votes  out  7  saturating count of cast votes.
- session_full  out  1  total_votes == MAX_VOTES.

## Operation
- States: IDLE, WAIT_ARM, ARMED, QUALIFY, CAST, RELEASE.
- IDLE: go to WAIT_ARM when session_open=1.
- WAIT_ARM: on a ballot_arm rising edge (prev sample 0, current 1) with session_full=0 and voter_switch=000, go to ARMED. The arm edge is ignored if the switch is non-zero or the session is full.
- ARMED: ballot_ready=1. Clear the timeout counter on entry. If voter_switch≠000, go to QUALIFY with stable_cnt=1 and latch the pattern.
- QUALIFY: ballot_ready=1.
  - Same pattern: stable_cnt++ (saturates at STABLE_CYCLES).
  - Pattern changes to another non-zero value: relatch it, stable_cnt=1.
  - Pattern returns to 000: go back to ARMED.
  - At stable_cnt==STABLE_CYCLES with a one-hot pattern: go to CAST.
  - At stable_cnt==STABLE_CYCLES with a non-one-hot pattern: invalid=1 and no cast. Stay in QUALIFY until the pattern changes.
- CAST: lasts exactly one cycle. voting_en=1 and vote_sel=latched pattern. total_votes increments by 1, saturating at MAX_VOTES. Then go to RELEASE.
- RELEASE: wait for voter_switch=000, then go to WAIT_ARM. A new arm edge is not accepted before RELEASE exits.
- Timeout: the counter runs in ARMED and QUALIFY. When it reaches TIMEOUT_CYCLES-1, pulse timeout, drop ballot_ready, and go to RELEASE. A CAST transition on the same edge takes priority over timeout.
- session_open=0 moves any state to IDLE on the next edge, except CAST, which completes and then goes to IDLE. total_votes is retained; only rst clears it.
- invalid=0 in every state other than QUALIFY.

## Timing
- Reset values: state=IDLE; voting_en=0, vote_sel=000, ballot_ready=0, invalid=0, timeout=0, total_votes=0, session_full=0. Stability and timeout counters are 0.
- Reset mid-CAST: voting_en deasserts asynchronously and no count is issued.
- Arm latency: arm edge sampled at edge n → ballot_ready=1 from edge n+1.
- Cast latency: one-hot pattern first sampled at edge m and held → voting_en high in the cycle following edge m+STABLE_CYCLES, for exactly one cycle.
- total_votes updates at the edge ending CAST. session_full follows the same edge.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Structure
- Package evm_pkg holds:
  - state enum evm_ctrl_state_t;
  - VOTE_W=7;
  - one-hot constants PARTY1=3'b001, PARTY2=3'b010, PARTY3=3'b100;
  - function is_onehot3.
- Sub-module evm_switch_qualifier holds the pattern latch, stability counter and one-hot check. Its outputs are stable, pattern and onehot.
- Top-level FSM, timeout counter, vote tally and output registers live in evm_ballot_ctrl.

## Test plan
- rst, session_open=1, arm pulse, switch=001 held 4 cycles → one voting_en pulse with vote_sel=001, total_votes=1; after switch=000 → WAIT_ARM.
- Armed, switch=011 held 10 cycles → invalid=1 from the 4th sampled edge, no voting_en; change to 010 for 4 cycles → invalid=0, one cast with vote_sel=010.
- Armed, switch=100 for 2 cycles, then 000, then 100 for 4 → exactly one cast (bounce filtered).
- Armed, idle TIMEOUT_CYCLES=8 → timeout pulse at the 8th cycle, ballot_ready=0, no cast; next arm accepted.
- 127 casts → session_full=1; the 128th arm edge is ignored and total_votes stays 127.
- session_open drops in QUALIFY → IDLE, no cast; rst asserted mid-session → all outputs 0 immediately.
